// File: rtl/wb_slot_scheduler_pkg.sv
// Shared types for the writeback slot scheduler: source encoding, slot entry
// layout and parameter legality bounds.
package wb_sched_pkg;

    // Encoding matches the writeback data mux select.
    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MUL = 2'b01,
        SRC_DIV = 2'b10,
        SRC_LSU = 2'b11
    } wb_src_t;

    typedef struct packed {
        logic    valid;
        wb_src_t src;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, src: SRC_ALU};

    localparam int MUL_LAT_MIN    = 2;
    localparam int STARVE_LIM_MIN = 1;

endpackage

// File: rtl/wb_slot_scheduler_if.sv
// Issue-side and variable-latency-unit request/grant signals of the writeback
// slot scheduler.
interface wb_slot_scheduler_if;

    logic fix_req_valid;
    logic fix_req_src;
    logic fix_req_grant;
    logic div_req_valid;
    logic div_req_ready;
    logic lsu_req_valid;
    logic lsu_req_ready;

    modport master (
        output fix_req_valid, fix_req_src, div_req_valid, lsu_req_valid,
        input  fix_req_grant, div_req_ready, lsu_req_ready
    );

    modport slave (
        input  fix_req_valid, fix_req_src, div_req_valid, lsu_req_valid,
        output fix_req_grant, div_req_ready, lsu_req_ready
    );

endinterface

// File: rtl/wb_slot_scheduler_var_arbiter.sv
// Round-robin arbiter between DIV and LSU writeback requests with saturating
// starvation counters; reports starvation so ALU issue can yield.
module wb_var_arbiter #(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic div_valid,
    input  logic lsu_valid,
    input  logic slot_free,
    output logic div_ready,
    output logic lsu_ready,
    output logic starve
);

    localparam int            CW  = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic [CW-1:0] div_wait;
    logic [CW-1:0] lsu_wait;
    logic          rr_ptr;      // 0: DIV first, 1: LSU first
    logic          div_starve;
    logic          lsu_starve;
    logic          pick_div;

    always_comb begin
        // NOTE: every output gets a value on every path so no latch is inferred.
        pick_div   = div_valid;
        div_starve = div_valid && (div_wait >= LIM);
        lsu_starve = lsu_valid && (lsu_wait >= LIM);
        starve     = div_starve || lsu_starve;
        if (div_valid && lsu_valid) begin
            if (div_starve != lsu_starve) pick_div = div_starve;
            else                          pick_div = !rr_ptr;
        end
        div_ready = clk_en && slot_free && div_valid && pick_div;
        lsu_ready = clk_en && slot_free && lsu_valid && !pick_div;
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_wait <= '0;
            lsu_wait <= '0;
            rr_ptr   <= 1'b0;
        end else if (clk_en) begin
            if (div_ready || !div_valid) div_wait <= '0;
            else if (div_wait < LIM)     div_wait <= div_wait + CW'(1);

            if (lsu_ready || !lsu_valid) lsu_wait <= '0;
            else if (lsu_wait < LIM)     lsu_wait <= lsu_wait + CW'(1);

            // Point at the unit that was not just served.
            if (div_ready)      rr_ptr <= 1'b1;
            else if (lsu_ready) rr_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_slot_scheduler.sv
// Writeback port scheduler: fixed-latency units book future slots at issue,
// variable-latency units take free next-cycle slots via wb_var_arbiter.
module wb_slot_scheduler
    import wb_sched_pkg::*;
#(
    parameter int MAX_LAT    = 4,
    parameter int MUL_LAT    = 3,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    wb_slot_scheduler_if.slave    bus,
    output wb_src_t               wb_sel,
    output logic                  wb_sel_valid,
    output logic [MAX_LAT-1:0]    slot_busy
);

    if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MAX_LAT) begin : g_bad_mul_lat
        $error("wb_slot_scheduler: MUL_LAT must be in 2..MAX_LAT");
    end
    if (STARVE_LIM < STARVE_LIM_MIN) begin : g_bad_starve_lim
        $error("wb_slot_scheduler: STARVE_LIM must be at least 1");
    end

    slot_t slot_q [MAX_LAT];
    slot_t slot_d [MAX_LAT];

    logic alu_req;
    logic mul_req;
    logic alu_grant;
    logic mul_grant;
    logic slot1_free;
    logic mul_free;
    logic var_slot_free;
    logic starve;

    assign alu_req    = bus.fix_req_valid && !bus.fix_req_src;
    assign mul_req    = bus.fix_req_valid &&  bus.fix_req_src;
    assign slot1_free = !slot_q[1].valid;

    // A MUL landing at the window edge targets a slot that is always empty.
    if (MUL_LAT >= MAX_LAT) begin : g_mul_edge
        assign mul_free = 1'b1;
    end else begin : g_mul_in
        assign mul_free = !slot_q[MUL_LAT].valid;
    end

    assign alu_grant         = clk_en && alu_req && slot1_free && !starve;
    assign mul_grant         = clk_en && mul_req && mul_free;
    assign bus.fix_req_grant = alu_grant || mul_grant;
    assign var_slot_free     = slot1_free && !(alu_req && !starve);

    wb_var_arbiter #(.STARVE_LIM(STARVE_LIM)) u_var_arb (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .div_valid (bus.div_req_valid),
        .lsu_valid (bus.lsu_req_valid),
        .slot_free (var_slot_free),
        .div_ready (bus.div_req_ready),
        .lsu_ready (bus.lsu_req_ready),
        .starve    (starve)
    );

    always_comb begin
        for (int k = 0; k < MAX_LAT - 1; k++) slot_d[k] = slot_q[k+1];
        slot_d[MAX_LAT-1] = SLOT_EMPTY;
        if (alu_grant)         slot_d[0] = '{valid: 1'b1, src: SRC_ALU};
        if (bus.div_req_ready) slot_d[0] = '{valid: 1'b1, src: SRC_DIV};
        if (bus.lsu_req_ready) slot_d[0] = '{valid: 1'b1, src: SRC_LSU};
        if (mul_grant)         slot_d[MUL_LAT-1] = '{valid: 1'b1, src: SRC_MUL};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the table is a handful of flops, so every entry is reset to discard bookings.
            for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= SLOT_EMPTY;
        end else if (clk_en) begin
            slot_q <= slot_d;
        end
    end

    assign wb_sel       = slot_q[0].src;
    assign wb_sel_valid = slot_q[0].valid;

    always_comb begin
        for (int k = 0; k < MAX_LAT; k++) slot_busy[k] = slot_q[k].valid;
    end

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Bench for wb_slot_scheduler: directed scenarios plus randomized traffic,
// checked against an absolute-time booking model of writeback ownership.
module tb_wb_slot_scheduler;
    import wb_sched_pkg::*;

    localparam int MAX_LAT    = 4;
    localparam int MUL_LAT    = 3;
    localparam int STARVE_LIM = 4;
    localparam int RING       = 64;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic [1:0]         wb_sel;
    logic               wb_sel_valid;
    logic [MAX_LAT-1:0] slot_busy;

    always #5 clk = ~clk;

    wb_slot_scheduler_if bus ();

    wb_slot_scheduler #(
        .MAX_LAT    (MAX_LAT),
        .MUL_LAT    (MUL_LAT),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .bus          (bus),
        .wb_sel       (wb_sel),
        .wb_sel_valid (wb_sel_valid),
        .slot_busy    (slot_busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: ownership of absolute enabled-cycle numbers, plus wait counts.
    bit booked [RING];
    int owner  [RING];
    int t;
    int div_wait_m;
    int lsu_wait_m;
    bit lsu_first;
    bit exp_div_g;
    bit exp_lsu_g;

    logic       o_fix, o_div, o_lsu, o_selv;
    logic [1:0] o_sel;
    logic [3:0] o_busy;

    function automatic int ix(input int c);
        return c % RING;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RING; i++) begin
            booked[i] = 1'b0;
            owner[i]  = 0;
        end
        t          = 0;
        div_wait_m = 0;
        lsu_wait_m = 0;
        lsu_first  = 1'b0;
    endtask

    task automatic book(input int cyc, input int src);
        checks++;
        if (booked[ix(cyc)]) begin
            errors++;
            $display("FAIL double_booking cycle=%0d got owner %0d exp free", cyc, owner[ix(cyc)]);
        end
        booked[ix(cyc)] = 1'b1;
        owner[ix(cyc)]  = src;
    endtask

    // One clock cycle: drive, compare against model at negedge, advance model.
    task automatic step(input bit fv, input bit fs, input bit dv, input bit lv, input bit en);
        bit e_fix, e_div, e_lsu, starve, alu_free, mul_free, var_free, e_selv;
        bit d_st, l_st;
        logic [1:0] e_sel;
        logic [3:0] e_busy;
        bus.fix_req_valid = fv;
        bus.fix_req_src   = fs;
        bus.div_req_valid = dv;
        bus.lsu_req_valid = lv;
        clk_en            = en;
        @(negedge clk);
        d_st     = dv && (div_wait_m >= STARVE_LIM);
        l_st     = lv && (lsu_wait_m >= STARVE_LIM);
        starve   = d_st || l_st;
        alu_free = !booked[ix(t + 1)];
        mul_free = (MUL_LAT >= MAX_LAT) || !booked[ix(t + MUL_LAT)];
        e_fix    = en && fv && (fs ? mul_free : (alu_free && !starve));
        var_free = en && alu_free && !(fv && !fs && !starve);
        e_div = 1'b0;
        e_lsu = 1'b0;
        if (var_free) begin
            if (dv && lv) begin
                e_div = (d_st != l_st) ? d_st : !lsu_first;
                e_lsu = !e_div;
            end else begin
                e_div = dv;
                e_lsu = lv;
            end
        end
        e_selv = booked[ix(t)];
        e_sel  = e_selv ? 2'(owner[ix(t)]) : 2'b00;
        for (int k = 0; k < MAX_LAT; k++) e_busy[k] = booked[ix(t + k)];

        o_fix  = bus.fix_req_grant;
        o_div  = bus.div_req_ready;
        o_lsu  = bus.lsu_req_ready;
        o_sel  = wb_sel;
        o_selv = wb_sel_valid;
        o_busy = slot_busy;

        checks += 6;
        if (o_fix !== e_fix) begin errors++; $display("FAIL fix_req_grant t=%0d got %b exp %b", t, o_fix, e_fix); end
        if (o_div !== e_div) begin errors++; $display("FAIL div_req_ready t=%0d got %b exp %b", t, o_div, e_div); end
        if (o_lsu !== e_lsu) begin errors++; $display("FAIL lsu_req_ready t=%0d got %b exp %b", t, o_lsu, e_lsu); end
        if (o_selv !== e_selv) begin errors++; $display("FAIL wb_sel_valid t=%0d got %b exp %b", t, o_selv, e_selv); end
        if (o_sel !== e_sel) begin errors++; $display("FAIL wb_sel t=%0d got %0d exp %0d", t, o_sel, e_sel); end
        if (o_busy !== e_busy) begin errors++; $display("FAIL slot_busy t=%0d got %b exp %b", t, o_busy, e_busy); end

        exp_div_g = e_div;
        exp_lsu_g = e_lsu;
        if (en) begin
            if (e_fix && fs)  book(t + MUL_LAT, int'(SRC_MUL));
            if (e_fix && !fs) book(t + 1, int'(SRC_ALU));
            if (e_div)        book(t + 1, int'(SRC_DIV));
            if (e_lsu)        book(t + 1, int'(SRC_LSU));
            div_wait_m = (e_div || !dv) ? 0 : ((div_wait_m < STARVE_LIM) ? div_wait_m + 1 : div_wait_m);
            lsu_wait_m = (e_lsu || !lv) ? 0 : ((lsu_wait_m < STARVE_LIM) ? lsu_wait_m + 1 : lsu_wait_m);
            if (e_div) lsu_first = 1'b1;
            if (e_lsu) lsu_first = 1'b0;
            booked[ix(t)] = 1'b0;
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fix_req_valid = 1'b0;
        bus.fix_req_src   = 1'b0;
        bus.div_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        clk_en            = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        step(1, 1, 1, 0, 1);
        step(1, 1, 0, 1, 1);
        checks++;
        if (slot_busy !== 4'b0111) begin errors++; $display("FAIL pre_reset_busy got %b exp 0111", slot_busy); end
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        checks += 2;
        if (wb_sel_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b exp 0", wb_sel_valid); end
        if (slot_busy !== 4'b0000) begin errors++; $display("FAIL async_reset_busy got %b exp 0000", slot_busy); end
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 1);
        checks++;
        if (o_fix !== 1'b1) begin errors++; $display("FAIL reset_alu_grant got %b exp 1", o_fix); end
        step(0, 0, 0, 0, 1);
        checks += 2;
        if (o_sel !== SRC_ALU) begin errors++; $display("FAIL reset_alu_wb got %0d exp 0", o_sel); end
        if (o_selv !== 1'b1) begin errors++; $display("FAIL reset_alu_wb_valid got %b exp 1", o_selv); end
    endtask

    task automatic test_mul_blocks_alu();
        do_reset();
        step(1, 1, 0, 0, 1);
        checks++;
        if (o_fix !== 1'b1) begin errors++; $display("FAIL mul_issue got %b exp 1", o_fix); end
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        checks++;
        if (o_fix !== 1'b0) begin errors++; $display("FAIL alu_denied_by_mul got %b exp 0", o_fix); end
        step(1, 0, 0, 0, 1);
        checks += 2;
        if (o_fix !== 1'b1) begin errors++; $display("FAIL alu_regrant got %b exp 1", o_fix); end
        if (o_sel !== SRC_MUL) begin errors++; $display("FAIL mul_wb got %0d exp 1", o_sel); end
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_sel !== SRC_ALU) begin errors++; $display("FAIL alu_after_mul_wb got %0d exp 0", o_sel); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 1);
            if (i < 4) begin
                checks += 2;
                if (o_div !== (i % 2 == 0)) begin errors++; $display("FAIL rr_div cyc=%0d got %b", i, o_div); end
                if (o_lsu !== (i % 2 == 1)) begin errors++; $display("FAIL rr_lsu cyc=%0d got %b", i, o_lsu); end
            end
            if (i >= 1) begin
                checks++;
                if (o_sel !== ((i % 2 == 1) ? SRC_DIV : SRC_LSU))
                    begin errors++; $display("FAIL rr_wb cyc=%0d got %0d", i, o_sel); end
            end
        end
    endtask

    task automatic test_starvation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 1);
            checks += 2;
            if (o_fix !== (i < 4)) begin errors++; $display("FAIL starve_alu cyc=%0d got %b exp %b", i, o_fix, i < 4); end
            if (o_div !== (i == 4)) begin errors++; $display("FAIL starve_div cyc=%0d got %b exp %b", i, o_div, i == 4); end
        end
        step(1, 0, 0, 0, 1);
        checks++;
        if (o_sel !== SRC_DIV) begin errors++; $display("FAIL starve_div_wb got %0d exp 2", o_sel); end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0, 1);
            checks++;
            if (o_div !== 1'b0) begin errors++; $display("FAIL div_wait_cleared cyc=%0d got %b exp 0", i, o_div); end
        end
    endtask

    task automatic test_mul_vs_div();
        do_reset();
        step(1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        checks++;
        if (o_div !== 1'b0) begin errors++; $display("FAIL div_blocked_by_mul got %b exp 0", o_div); end
        step(0, 0, 1, 0, 1);
        checks += 2;
        if (o_div !== 1'b1) begin errors++; $display("FAIL div_after_mul got %b exp 1", o_div); end
        if (o_sel !== SRC_MUL) begin errors++; $display("FAIL mul_before_div_wb got %0d exp 1", o_sel); end
        step(0, 0, 0, 0, 1);
        checks++;
        if (o_sel !== SRC_DIV) begin errors++; $display("FAIL div_wb got %0d exp 2", o_sel); end
    endtask

    task automatic test_clk_en();
        do_reset();
        step(1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, i == 1, 0, 0, 0);
            checks += 3;
            if (o_fix !== 1'b0) begin errors++; $display("FAIL frozen_grant cyc=%0d got %b exp 0", i, o_fix); end
            if (o_busy !== 4'b0010) begin errors++; $display("FAIL frozen_busy cyc=%0d got %b exp 0010", i, o_busy); end
            if (o_selv !== 1'b0) begin errors++; $display("FAIL frozen_valid cyc=%0d got %b exp 0", i, o_selv); end
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks += 2;
        if (o_sel !== SRC_MUL) begin errors++; $display("FAIL mul_after_freeze got %0d exp 1", o_sel); end
        if (o_selv !== 1'b1) begin errors++; $display("FAIL mul_after_freeze_valid got %b exp 1", o_selv); end
    endtask

    task automatic test_random();
        bit dv, lv, fv, fs, en;
        do_reset();
        dv = 1'b0;
        lv = 1'b0;
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 7) != 0);
            fv = ($urandom_range(0, 2) != 0);
            fs = $urandom_range(0, 1) == 1;
            if (!dv) dv = ($urandom_range(0, 2) == 0);
            if (!lv) lv = ($urandom_range(0, 2) == 0);
            step(fv, fs, dv, lv, en);
            // Valid is held until accepted; a fresh result may follow at once.
            if (exp_div_g) dv = ($urandom_range(0, 1) == 1);
            if (exp_lsu_g) lv = ($urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        test_reset();
        test_mul_blocks_alu();
        test_round_robin();
        test_starvation();
        test_mul_vs_div();
        test_clk_en();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_slot_scheduler.md
Name: wb_slot_scheduler

Overview:
- Schedules ownership of the single register-file writeback port between four result sources: ALU, MUL, DIV and LSU.
- Fixed-latency units (ALU, MUL) reserve a future writeback slot at issue time; issue is denied when that slot is already owned.
- Variable-latency units (DIV, LSU) present finished results with a valid/ready handshake and are granted only free slots, round-robin between them, with starvation protection against ALU issue.
- Sits between issue and the writeback stage and removes writeback conflict stalls by construction.

Parameters:
MAX_LAT, 4, depth of the reservation window in cycles; must be at least MUL_LAT.
MUL_LAT, 3, fixed MUL issue-to-writeback latency; legal range 2..MAX_LAT.
STARVE_LIM, 4, consecutive denied cycles after which a variable requester beats ALU issue.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clk_en  in  1  global clock enable; low freezes all state
fix_req_valid  in  1  issue stage wants to issue to a fixed-latency unit this cycle
fix_req_src  in  1  0 = ALU (latency 1), 1 = MUL (latency MUL_LAT)
fix_req_grant  out  1  combinational grant; issue proceeds only when high
div_req_valid  in  1  DIV result ready to write back
div_req_ready  out  1  combinational DIV grant
lsu_req_valid  in  1  LSU result ready to write back
lsu_req_ready  out  1  combinational LSU grant
wb_sel  out  2  registered owner of the current writeback cycle (wb_src_t)
wb_sel_valid  out  1  registered; the current cycle has a writeback owner
slot_busy  out  MAX_LAT  debug; bit k set means a slot is owned k cycles ahead

Behaviour:
- State:
  - slot table slot[0..MAX_LAT-1], each entry {valid, src}; slot[0] drives wb_sel and wb_sel_valid.
  - rr_ptr: 0 = DIV first, 1 = LSU first.
  - Saturating counters div_wait and lsu_wait, each ceil(log2(STARVE_LIM+1)) bits.
- Reset: all slot valids = 0, rr_ptr = 0, counters = 0, wb_sel = 0, wb_sel_valid = 0, slot_busy = 0. Asynchronous reset takes effect immediately, mid-operation included; pending reservations are discarded.
- Timing: a request is sampled in cycle t. A grant with latency L owns writeback in cycle t+L. Variable-unit latency = 1.
- Per clk_en edge:
  - slot[k] <= slot[k+1]; slot[MAX_LAT-1] <= empty.
  - A granted reservation is written to slot[L-1] of the shifted table.
- Slot checks are made on the pre-shift table:
  - ALU request is free when slot[1] is empty.
  - MUL request is free when slot[MUL_LAT] is empty; index MAX_LAT is always free.
  - Variable requests are free when slot[1] is empty.
- Contention for slot[1] (ALU vs DIV/LSU):
  - starve = (div_valid && div_wait >= STARVE_LIM) || (lsu_valid && lsu_wait >= STARVE_LIM).
  - If starve, the variable side wins and the ALU grant is 0. Otherwise ALU wins.
- MUL reservations never contend with variable grants in the same cycle, because they target different slots. Both may be granted together.
- DIV/LSU arbitration: at most one variable grant per cycle.
  - If only one is valid, it gets the grant.
  - If both are valid and exactly one is starving, the starving one wins.
  - Otherwise rr_ptr decides. rr_ptr toggles to the other unit after each variable grant.
- Counters:
  - A counter increments (saturating) when its unit is valid and not ready.
  - It clears on grant, or when its valid is low.
- Handshake rules:
  - Requesters hold valid until ready. ready may be high only when valid is high.
  - A grant is a valid && ready transfer.
  - The scheduler never revokes a granted slot.
- clk_en = 0: all grants and readys forced to 0; table, counters and outputs hold.
- fix_req_grant = fix_req_valid && free && !(ALU && starve-loss) && clk_en.
- Invariant: at most one owner per slot; wb_sel_valid never reflects a double booking.

Decomposition:
- Package wb_sched_pkg holds:
  - wb_src_t: ALU = 2'b00, MUL = 2'b01, DIV = 2'b10, LSU = 2'b11, matching the writeback mux encoding.
  - slot_t struct {valid, src}.
  - Parameter range-check constants.
- Sub-module wb_var_arbiter: the two-requester round-robin with starvation counters. Inputs: the valids and slot_free. Outputs: the readys and starve.

Test Plan (MAX_LAT = 4, MUL_LAT = 3, STARVE_LIM = 4):
1. Assert rst asynchronously with 3 slots reserved, no clock edge -> wb_sel_valid = 0, slot_busy = 4'b0000 immediately. After release, ALU request in cycle 0 -> grant = 1, wb_sel = ALU, wb_sel_valid = 1 in cycle 1.
2. MUL issued cycle 0; ALU request cycle 2 -> fix_req_grant = 0 in cycle 2 (cycle 3 owned by MUL). ALU regrants in cycle 3. wb_sel = MUL in cycle 3, ALU in cycle 4.
3. DIV and LSU valid continuously, no fixed requests -> readys alternate DIV, LSU, DIV, LSU from cycle 0. wb_sel = 2, 3, 2, 3 from cycle 1.
4. ALU requests every cycle; DIV valid from cycle 0 -> DIV denied cycles 0–3. Cycle 4: div_req_ready = 1, ALU grant = 0, wb_sel = DIV in cycle 5. div_wait back to 0.
5. MUL granted cycle 0; DIV valid from cycle 2 -> div_req_ready = 0 in cycle 2, 1 in cycle 3. Writebacks: MUL in cycle 3, DIV in cycle 4.
6. clk_en low for cycles 2–4 with a MUL pending -> grants = 0, slot_busy and wb_sel frozen. MUL writes back 3 enabled cycles after issue.
